// File: rtl/pe_dbuf.sv
// pe_dbuf: weight-stationary systolic MAC cell with double-buffered weights.
//
// A shadow weight shifts down the column while the active weight keeps
// computing. A swap pulse travels down the column alongside the weights and
// commits shadow to active without stalling the MAC.
//
// Optional feature macro: PE_SAT_EN (saturating psum add, drives sat_out).
//
// Ports:
//   clk, rstn             clock (rising edge), asynchronous active-low reset
//   en_in / en_out        activation/psum valid in, registered copy out
//   in / pass_out         activation from left, registered to right
//   psum_in / psum_out    partial sum from above, registered MAC result below
//   w_wen_in / w_wen_out  weight-shift strobe in, registered copy out
//   w_in / w_out          weight from above, displaced shadow value below
//   w_swap_in/w_swap_out  shadow->active commit pulse in, registered copy out
//   w_valid               active weight loaded since reset
//   sat_out               psum saturated this cycle (0 without PE_SAT_EN)
module pe_dbuf #(
    parameter int DATA_WIDTH = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en_in,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    input  logic                  w_wen_in,
    input  logic [DATA_WIDTH-1:0] w_in,
    input  logic                  w_swap_in,
    output logic                  en_out,
    output logic [DATA_WIDTH-1:0] pass_out,
    output logic [PSUM_WIDTH-1:0] psum_out,
    output logic                  w_wen_out,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic                  w_swap_out,
    output logic                  w_valid,
    output logic                  sat_out
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = PSUM_WIDTH;

    if (PW < 2 * DW) begin : g_bad_width
        $error("pe_dbuf: PSUM_WIDTH must be >= 2*DATA_WIDTH");
    end

    logic          en_q, en_d;
    logic [DW-1:0] pass_q, pass_d;
    logic [PW-1:0] psum_q, psum_d;
    logic          w_wen_q, w_wen_d;
    logic [DW-1:0] w_out_q, w_out_d;
    logic          w_swap_q, w_swap_d;
    logic          w_valid_q, w_valid_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic          shadow_valid_q, shadow_valid_d;
    logic [DW-1:0] active_q, active_d;
    logic [PW-1:0] in_x, act_x, prod;
    logic          commit;

    // Operands are extended to PW before multiplying; since PW >= 2*DW the
    // low PW bits equal the 2*DW product extended per SIGNED.
    always_comb begin
        in_x   = {{(PW-DW){(SIGNED != 0) && in[DW-1]}}, in};
        act_x  = {{(PW-DW){(SIGNED != 0) && active_q[DW-1]}}, active_q};
        prod   = in_x * act_x;
        commit = w_swap_in && shadow_valid_q;
    end

`ifdef PE_SAT_EN
    logic [PW:0]   sum;
    logic          ovf;
    logic [PW-1:0] clamp;
    logic          sat_q, sat_d;

    // One guard bit above the psum width detects overflow of the add.
    always_comb begin
        sum   = (SIGNED != 0) ? {psum_in[PW-1], psum_in} + {prod[PW-1], prod}
                              : {1'b0, psum_in} + {1'b0, prod};
        ovf   = (SIGNED != 0) ? sum[PW] ^ sum[PW-1] : sum[PW];
        clamp = (SIGNED != 0) ? (sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}})
                              : {PW{1'b1}};
        psum_d = en_in ? (ovf ? clamp : sum[PW-1:0]) : psum_q;
        sat_d  = en_in && ovf;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sat_q <= 1'b0;
        else       sat_q <= sat_d;
    end

    assign sat_out = sat_q;
`else
    always_comb psum_d = en_in ? psum_in + prod : psum_q;

    assign sat_out = 1'b0;
`endif

    // A shift in the same cycle as a swap refills the shadow, so the shift
    // wins the shadow_valid update.
    always_comb begin
        en_d           = en_in;
        pass_d         = en_in ? in : pass_q;
        w_wen_d        = w_wen_in;
        w_swap_d       = w_swap_in;
        shadow_d       = w_wen_in ? w_in : shadow_q;
        w_out_d        = w_wen_in ? shadow_q : '0;
        active_d       = commit ? shadow_q : active_q;
        w_valid_d      = w_valid_q || commit;
        shadow_valid_d = w_wen_in || (shadow_valid_q && !w_swap_in);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q           <= 1'b0;
            pass_q         <= '0;
            psum_q         <= '0;
            w_wen_q        <= 1'b0;
            w_out_q        <= '0;
            w_swap_q       <= 1'b0;
            w_valid_q      <= 1'b0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            active_q       <= '0;
        end else begin
            en_q           <= en_d;
            pass_q         <= pass_d;
            psum_q         <= psum_d;
            w_wen_q        <= w_wen_d;
            w_out_q        <= w_out_d;
            w_swap_q       <= w_swap_d;
            w_valid_q      <= w_valid_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            active_q       <= active_d;
        end
    end

    assign en_out     = en_q;
    assign pass_out   = pass_q;
    assign psum_out   = psum_q;
    assign w_wen_out  = w_wen_q;
    assign w_out      = w_out_q;
    assign w_swap_out = w_swap_q;
    assign w_valid    = w_valid_q;
endmodule

// File: tb/tb_pe_dbuf.sv
// tb_pe_dbuf: randomized and directed checks of pe_dbuf against a behavioural model.
module tb_pe_dbuf;
    localparam int DW = 16;
    localparam int PW = 32;
    localparam int SG = 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en_in = 1'b0;
    logic [DW-1:0] in_v = '0;
    logic [PW-1:0] psum_in = '0;
    logic          w_wen_in = 1'b0;
    logic [DW-1:0] w_in = '0;
    logic          w_swap_in = 1'b0;
    logic          en_out, w_wen_out, w_swap_out, w_valid, sat_out;
    logic [DW-1:0] pass_out, w_out;
    logic [PW-1:0] psum_out;

    int n_total = 0;
    int n_pass  = 0;

    logic [DW-1:0] m_shadow, m_active;
    logic          m_sv, m_wvalid;
    logic          e_en, e_wwen, e_wswap, e_sat;
    logic [DW-1:0] e_pass, e_wout;
    logic [PW-1:0] e_psum;

    pe_dbuf #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .SIGNED(SG)) dut (
        .clk(clk), .rstn(rstn), .en_in(en_in), .in(in_v), .psum_in(psum_in),
        .w_wen_in(w_wen_in), .w_in(w_in), .w_swap_in(w_swap_in),
        .en_out(en_out), .pass_out(pass_out), .psum_out(psum_out),
        .w_wen_out(w_wen_out), .w_out(w_out), .w_swap_out(w_swap_out),
        .w_valid(w_valid), .sat_out(sat_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Full-precision arithmetic, then wrap or clamp to PW bits.
    task automatic mac(input logic [DW-1:0] a, input logic [DW-1:0] w, input logic [PW-1:0] p,
                       output logic [PW-1:0] r, output logic s);
        longint av, wv, pv, sum, lo, hi;
        if (SG != 0) begin
            av = longint'($signed(a));
            wv = longint'($signed(w));
            pv = longint'($signed(p));
            lo = -64'sd2147483648;
            hi = 64'sd2147483647;
        end else begin
            av = longint'(a);
            wv = longint'(w);
            pv = longint'(p);
            lo = 0;
            hi = 64'sd4294967295;
        end
        sum = av * wv + pv;
`ifdef PE_SAT_EN
        s = (sum < lo) || (sum > hi);
        r = (sum < lo) ? lo[PW-1:0] : (sum > hi) ? hi[PW-1:0] : sum[PW-1:0];
`else
        s = 1'b0;
        r = sum[PW-1:0];
        if (lo > hi) r = '0;
`endif
    endtask

    task automatic model_reset();
        m_shadow = '0; m_active = '0; m_sv = 0; m_wvalid = 0;
        e_en = 0; e_wwen = 0; e_wswap = 0; e_sat = 0;
        e_pass = '0; e_wout = '0; e_psum = '0;
    endtask

    task automatic model_step();
        logic nsv;
        e_en = en_in; e_wwen = w_wen_in; e_wswap = w_swap_in;
        if (en_in) begin
            e_pass = in_v;
            mac(in_v, m_active, psum_in, e_psum, e_sat);
        end else e_sat = 0;
        e_wout = w_wen_in ? m_shadow : '0;
        nsv = m_sv;
        if (w_swap_in && m_sv) begin
            m_active = m_shadow; m_wvalid = 1; nsv = 0;
        end
        if (w_wen_in) begin
            m_shadow = w_in; nsv = 1;
        end
        m_sv = nsv;
    endtask

    task automatic compare();
        chk("en_out", 64'(en_out), 64'(e_en));
        chk("pass_out", 64'(pass_out), 64'(e_pass));
        chk("psum_out", 64'(psum_out), 64'(e_psum));
        chk("w_wen_out", 64'(w_wen_out), 64'(e_wwen));
        chk("w_out", 64'(w_out), 64'(e_wout));
        chk("w_swap_out", 64'(w_swap_out), 64'(e_wswap));
        chk("w_valid", 64'(w_valid), 64'(m_wvalid));
        chk("sat_out", 64'(sat_out), 64'(e_sat));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rstn) model_reset();
        else model_step();
        #1 compare();
    endtask

    task automatic idle();
        en_in = 0; w_wen_in = 0; w_swap_in = 0;
    endtask

    task automatic load_swap(input logic [DW-1:0] w);
        idle(); w_wen_in = 1; w_in = w; cycle();
        idle(); w_swap_in = 1; cycle();
        idle();
    endtask

    initial begin
        model_reset();
        #1 compare();
        cycle(); cycle();
        rstn = 1;
        // load and swap
        idle(); w_wen_in = 1; w_in = 5; cycle();
        idle(); w_swap_in = 1; cycle();
        chk("swap_out_pulse", 64'(w_swap_out), 64'd1);
        idle(); en_in = 1; in_v = 3; psum_in = 10; cycle();
        chk("load_swap_psum", 64'(psum_out), 64'd25);
        chk("swap_out_clear", 64'(w_swap_out), 64'd0);
        // double buffer: shadow updates while active keeps computing
        idle(); en_in = 1; in_v = 2; psum_in = 0; w_wen_in = 1; w_in = 7; cycle();
        chk("dbuf_c1", 64'(psum_out), 64'd10);
        w_wen_in = 0; cycle();
        chk("dbuf_c2", 64'(psum_out), 64'd10);
        cycle();
        chk("dbuf_c3", 64'(psum_out), 64'd10);
        w_swap_in = 1; cycle();
        chk("dbuf_swap_cycle", 64'(psum_out), 64'd10);
        w_swap_in = 0; cycle();
        chk("dbuf_after", 64'(psum_out), 64'd14);
        // swap + shift collision
        idle(); w_wen_in = 1; w_in = 4; cycle();
        idle(); w_swap_in = 1; w_wen_in = 1; w_in = 9; cycle();
        chk("collide_w_out", 64'(w_out), 64'd4);
        idle(); en_in = 1; in_v = 1; psum_in = 0; w_swap_in = 1; cycle();
        chk("collide_active4", 64'(psum_out), 64'd4);
        w_swap_in = 0; cycle();
        chk("collide_active9", 64'(psum_out), 64'd9);
        // signed multiply
        load_swap(4);
        en_in = 1; in_v = 16'hFFFD; psum_in = 2; cycle();
        chk("signed_psum", 64'(psum_out), 64'hFFFF_FFF6);
        // overflow
        load_swap(16'h0100);
        en_in = 1; in_v = 1; psum_in = 32'h7FFF_FFF0; cycle();
`ifdef PE_SAT_EN
        chk("sat_psum", 64'(psum_out), 64'h7FFF_FFFF);
        chk("sat_flag", 64'(sat_out), 64'd1);
`else
        chk("wrap_psum", 64'(psum_out), 64'h8000_00F0);
        chk("wrap_flag", 64'(sat_out), 64'd0);
`endif
        idle(); cycle();
        chk("hold_psum", 64'(psum_out), 64'(e_psum));
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en_in = ($urandom_range(0, 9) < 7);
            in_v = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000)
                                              : DW'($urandom);
            psum_in = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 32'h7FFF_FF00 : 32'h8000_0100)
                                                 : $urandom;
            w_wen_in = ($urandom_range(0, 1) != 0);
            w_in = DW'($urandom);
            w_swap_in = ($urandom_range(0, 5) == 0);
            cycle();
        end
        // asynchronous reset mid-stream
        en_in = 1; w_wen_in = 1; w_in = 16'h1234; in_v = 16'h55; psum_in = 32'h77; w_swap_in = 1;
        cycle();
        #2 rstn = 0;
        #1;
        chk("arst_en_out", 64'(en_out), 64'd0);
        chk("arst_pass_out", 64'(pass_out), 64'd0);
        chk("arst_psum_out", 64'(psum_out), 64'd0);
        chk("arst_w_wen_out", 64'(w_wen_out), 64'd0);
        chk("arst_w_out", 64'(w_out), 64'd0);
        chk("arst_w_swap_out", 64'(w_swap_out), 64'd0);
        chk("arst_w_valid", 64'(w_valid), 64'd0);
        chk("arst_sat_out", 64'(sat_out), 64'd0);
        model_reset();
        w_swap_in = 0;
        cycle(); cycle();
        rstn = 1;
        for (int i = 0; i < 4; i++) cycle();
        chk("post_reset_w_valid", 64'(w_valid), 64'd0);
        chk("post_reset_psum_passthru", 64'(psum_out), 64'h77);
        for (int i = 0; i < 100; i++) begin
            en_in = ($urandom_range(0, 1) != 0);
            in_v = DW'($urandom);
            psum_in = $urandom;
            w_wen_in = ($urandom_range(0, 1) != 0);
            w_in = DW'($urandom);
            w_swap_in = ($urandom_range(0, 3) == 0);
            cycle();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
